// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
// Latency: WIDTH+1 clocks from the accepting edge to the one-cycle done pulse; one conversion per WIDTH+2 clocks.
// Backpressure: start is honoured only while busy is low; requests made while busy are dropped, not queued.
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = 4 * DIGITS;

   // True when DIGITS decimal digits can hold 2^WIDTH-1. p stays below 10*2^WIDTH,
   // so WIDTH+4 bits never overflow during the search.
   function automatic bit digits_fit();
      logic [WIDTH+3:0] max_val;
      logic [WIDTH+3:0] p;
      max_val = {4'd0, {WIDTH{1'b1}}};
      p       = {{(WIDTH+3){1'b0}}, 1'b1};
      for (int i = 0; i < DIGITS; i++) begin
         p = p * 10;
         if (p > max_val) return 1'b1;
      end
      return 1'b0;
   endfunction

   if (!digits_fit()) begin : g_digits_check
      $error("bin2bcd_seq: DIGITS too small to represent 2^WIDTH-1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [SW-1:0]     scratch;
   logic [WIDTH-1:0]  sh;
   logic [CW-1:0]     cnt;
   logic [SW-1:0]     adj;
   logic [SW-1:0]     scratch_nx;
   logic [WIDTH-1:0]  sh_nx;
   logic              last;

   // The shift that moves cnt to WIDTH is the final one.
   assign last = (cnt == CW'(WIDTH - 1));

   // Per-nibble add-3 correction; nibbles are independent, no carries between them.
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         else
            adj[4*i +: 4] = scratch[4*i +: 4];
      end
   end

   // One-bit left shift of {scratch, sh}; the MSB of sh feeds bit 0 of scratch.
   always_comb begin
      scratch_nx = {adj[SW-2:0], sh[WIDTH-1]};
      sh_nx      = sh << 1;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_SHIFT;
         S_SHIFT: if (last)  state_nx = S_DONE;
         S_DONE:             state_nx = S_IDLE;
         default:            state_nx = S_IDLE;
      endcase
   end

   // Working registers and result; bcd is loaded only on the edge entering DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scratch <= '0;
         sh      <= '0;
         cnt     <= '0;
         bcd     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sh      <= bin;
                  scratch <= '0;
                  cnt     <= '0;
               end
            end
            S_SHIFT: begin
               scratch <= scratch_nx;
               sh      <= sh_nx;
               cnt     <= cnt + CW'(1);
               if (last) bcd <= scratch_nx;
            end
            default: ;
         endcase
      end
   end

   // Moore outputs decoded straight from the state register.
   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench for bin2bcd_seq at WIDTH=8/DIGITS=3 and WIDTH=16/DIGITS=5.
// Latency: checks done arrives WIDTH+1 cycles after the accepting edge.
// Backpressure: checks that starts issued while busy are dropped.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, start16;
   logic [7:0]  bin8;
   logic [15:0] bin16;
   logic        busy8, done8, busy16, done16;
   logic [11:0] bcd8;
   logic [19:0] bcd16;

   int n_checks = 0;
   int n_err    = 0;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .bin(bin8),
      .busy(busy8), .done(done8), .bcd(bcd8)
   );

   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .bin(bin16),
      .busy(busy16), .done(done16), .bcd(bcd16)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; issues start, then watches negedges n=1.. after the
   // accepting edge. mask[n] drives start during cycle n (to probe ignored starts).
   task automatic run(input bit wide, input logic [15:0] v, input bit [63:0] mask,
                      output logic [19:0] res, output int lat, output int bcyc, output int dones);
      logic b, d;
      bit   fin;
      lat = -1; bcyc = 0; dones = 0; res = '0; fin = 1'b0;
      if (wide) begin start16 = 1'b1; bin16 = v; end
      else      begin start8  = 1'b1; bin8  = v[7:0]; end
      @(posedge clk);
      #1;
      start8 = 1'b0; start16 = 1'b0;
      bin8 = ~bin8; bin16 = ~bin16;
      for (int n = 1; n <= 40 && !fin; n++) begin
         @(negedge clk);
         b = wide ? busy16 : busy8;
         d = wide ? done16 : done8;
         if (b) bcyc++;
         if (d) begin
            dones++;
            if (lat < 0) begin
               lat = n;
               res = wide ? bcd16 : {8'h00, bcd8};
            end
         end
         if (wide) start16 = mask[n];
         else      start8  = mask[n];
         if (!b && lat >= 0) fin = 1'b1;
      end
      start8 = 1'b0; start16 = 1'b0;
   endtask

   initial begin
      logic [19:0] res;
      logic [11:0] exp_b;
      int          lat, bcyc, dones, bad;
      logic [15:0] vals [4];
      logic [11:0] exps [4];

      rst = 1'b1; start8 = 1'b0; start16 = 1'b0; bin8 = '0; bin16 = '0;
      #12;
      check("rst_bcd8",   {20'h0, bcd8}, 32'h0);
      check("rst_busy8",  {31'h0, busy8}, 32'h0);
      check("rst_done8",  {31'h0, done8}, 32'h0);
      check("rst_bcd16",  {12'h0, bcd16}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full-scale 8-bit value with latency and busy length.
      run(1'b0, 16'd255, 64'h0, res, lat, bcyc, dones);
      check("b255_bcd",   {12'h0, res}, 32'h255);
      check("b255_lat",   lat,   9);
      check("b255_busy",  bcyc,  9);
      check("b255_dones", dones, 1);

      // Back-to-back conversions, each start the cycle after busy falls.
      vals = '{16'd0, 16'd9, 16'd10, 16'd15};
      exps = '{12'h000, 12'h009, 12'h010, 12'h015};
      for (int i = 0; i < 4; i++) begin
         run(1'b0, vals[i], 64'h0, res, lat, bcyc, dones);
         check($sformatf("b2b_%0d_bcd", vals[i]), {12'h0, res}, {20'h0, exps[i]});
         check($sformatf("b2b_%0d_lat", vals[i]), lat, 9);
      end

      // Starts during cycles 1, 4 and 8 of an active conversion are ignored.
      run(1'b0, 16'd123, 64'h112, res, lat, bcyc, dones);
      check("ign_bcd",   {12'h0, res}, 32'h123);
      check("ign_dones", dones, 1);
      check("ign_busy",  bcyc,  9);
      repeat (3) @(negedge clk);
      check("ign_idle",  {31'h0, busy8}, 32'h0);

      // Reset aborts a conversion in flight.
      start8 = 1'b1; bin8 = 8'd200;
      @(posedge clk);
      #1 start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_bcd",  {20'h0, bcd8}, 32'h0);
      check("abort_busy", {31'h0, busy8}, 32'h0);
      check("abort_done", {31'h0, done8}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (done8 || busy8) dones++;
      end
      check("abort_quiet", dones, 0);
      run(1'b0, 16'd77, 64'h0, res, lat, bcyc, dones);
      check("after_abort_bcd", {12'h0, res}, 32'h077);

      // Exhaustive 8-bit sweep against decimal digit reference.
      bad = 0;
      for (int v = 0; v < 256; v++) begin
         exp_b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         run(1'b0, 16'(v), 64'h0, res, lat, bcyc, dones);
         check($sformatf("sweep_%0d", v), {12'h0, res}, {20'h0, exp_b});
         for (int k = 0; k < 3; k++)
            if (res[4*k +: 4] > 4'd9) bad++;
      end
      check("sweep_digit_range", bad, 0);

      // 16-bit instance.
      run(1'b1, 16'd65535, 64'h0, res, lat, bcyc, dones);
      check("w16_65535_bcd", {12'h0, res}, 32'h65535);
      check("w16_65535_lat", lat, 17);
      run(1'b1, 16'd40960, 64'h0, res, lat, bcyc, dones);
      check("w16_40960_bcd", {12'h0, res}, 32'h40960);
      check("w16_40960_lat", lat, 17);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
